// File: rtl/muxn_pkg.sv
// Shared types and constants for the registered N:1 bus multiplexer.
package muxn_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int MAX_NUM_IN = 16;
    localparam int OR_FANIN   = 4;

    // Two levels of OR_FANIN-input ORs cover up to MAX_NUM_IN inputs.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/muxn_comb.sv
// Combinational N:1 select: one-hot decode gates every input, then a two-level
// tree of at most 4-input ORs merges them. Out-of-range selects yield zero data.
module muxn_comb
    import muxn_pkg::*;
#(
    parameter int  WIDTH  = 64,
    parameter int  NUM_IN = 8,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    err_o
);

    localparam int N_GRP = ceil_div(NUM_IN, OR_FANIN);

    logic [NUM_IN-1:0]            onehot;
    logic [NUM_IN-1:0][WIDTH-1:0] masked;
    logic [N_GRP-1:0][WIDTH-1:0]  grp_or;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_dec
            assign onehot[gi] = (sel_i == SEL_W'(gi));
            assign masked[gi] = data_i[gi*WIDTH +: WIDTH] & {WIDTH{onehot[gi]}};
        end

        for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
            // The last group may hold fewer than OR_FANIN inputs.
            localparam int NKIDS = (NUM_IN - gi*OR_FANIN >= OR_FANIN) ?
                                   OR_FANIN : (NUM_IN - gi*OR_FANIN);
            logic [WIDTH-1:0] acc;
            always_comb begin
                acc = '0;
                for (int k = 0; k < NKIDS; k++) begin
                    acc = acc | masked[gi*OR_FANIN + k];
                end
            end
            assign grp_or[gi] = acc;
        end
    endgenerate

    always_comb begin
        data_o = '0;
        for (int k = 0; k < N_GRP; k++) begin
            data_o = data_o | grp_or[k];
        end
    end

    assign err_o = ({1'b0, sel_i} >= (SEL_W+1)'(NUM_IN));

endmodule

// File: rtl/muxn_pipe.sv
// Registered N:1 bus multiplexer with valid/ready flow control through a
// 2-entry skid buffer (main reg drives the outputs, skid reg absorbs one stall).
module muxn_pipe
    import muxn_pkg::*;
#(
    parameter int  WIDTH  = 64,
    parameter int  NUM_IN = 8,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } beat_t;

    state_e           state_q;
    beat_t            m_q;
    beat_t            s_q;
    logic             in_ready_q;
    beat_t            beat_d;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             acc;
    logic             emt;

    muxn_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_comb (
        .sel_i  (in_sel),
        .data_i (in_data),
        .data_o (sel_data),
        .err_o  (sel_err)
    );

    assign beat_d = '{data: sel_data, sel: in_sel, err: sel_err};

    // out_valid decodes the state register so an async reset clears it at once.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign out_data  = m_q.data;
    assign out_sel   = m_q.sel;
    assign out_err   = m_q.err;

    assign acc = in_valid & in_ready_q;
    assign emt = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            m_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (acc) begin
                        m_q     <= beat_d;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (acc && emt) begin
                        m_q <= beat_d;
                    end else if (acc) begin
                        s_q        <= beat_d;
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (emt) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (emt) begin
                        m_q        <= s_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muxn_pipe.sv
// Directed and random checks of muxn_pipe (NUM_IN=8 and NUM_IN=6 instances).
module tb_muxn_pipe;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic         in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]   in_sel, out_sel;
    logic [511:0] in_data;
    logic [63:0]  out_data;

    logic         in_valid6, in_ready6, out_valid6, out_ready6, out_err6;
    logic [2:0]   in_sel6, out_sel6;
    logic [383:0] in_data6;
    logic [63:0]  out_data6;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  sel;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    muxn_pipe #(.WIDTH(64), .NUM_IN(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .out_err(out_err)
    );

    muxn_pipe #(.WIDTH(64), .NUM_IN(6)) dut6 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_sel(in_sel6), .in_data(in_data6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
        .out_sel(out_sel6), .out_err(out_err6)
    );

    function automatic logic [63:0] pat(input int i);
        return 64'h1111_0000_0000_0000 * 64'(i);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t        e;
        logic        acc, emt;
        logic [63:0] exp_d;

        for (int i = 0; i < 8; i++) in_data[i*64 +: 64] = pat(i);
        for (int i = 0; i < 6; i++) in_data6[i*64 +: 64] = pat(i);
        in_valid = 1'b1; in_sel = 3'd3; out_ready = 1'b1;
        in_valid6 = 1'b0; in_sel6 = 3'd0; out_ready6 = 1'b1;

        // 1: reset held with in_valid high
        cyc(); cyc();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        reset_n = 1'b1;
        in_valid = 1'b0;
        cyc();
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_out_valid", 64'(out_valid), 64'd0);
        check("rel_in_ready6", 64'(in_ready6), 64'd1);

        // 2: back-to-back streaming, sel 0..7
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_sel = 3'(i);
            cyc();
            check($sformatf("stream_valid_%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("stream_data_%0d", i), out_data, pat(i));
            check($sformatf("stream_sel_%0d", i), 64'(out_sel), 64'(i));
            check($sformatf("stream_rdy_%0d", i), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        cyc();
        check("stream_drain", 64'(out_valid), 64'd0);

        // 3: back-pressure for 4 cycles while upstream keeps offering beats
        in_valid = 1'b1; in_sel = 3'd1; out_ready = 1'b0;
        cyc();
        check("bp_c1_data", out_data, pat(1));
        check("bp_c1_rdy", 64'(in_ready), 64'd1);
        in_sel = 3'd2;
        cyc();
        check("bp_c2_data", out_data, pat(1));
        check("bp_c2_rdy", 64'(in_ready), 64'd0);
        in_sel = 3'd3;
        cyc();
        check("bp_c3_data", out_data, pat(1));
        check("bp_c3_rdy", 64'(in_ready), 64'd0);
        cyc();
        check("bp_c4_data", out_data, pat(1));
        check("bp_c4_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        cyc();
        check("bp_rel1_data", out_data, pat(2));
        check("bp_rel1_rdy", 64'(in_ready), 64'd1);
        cyc();
        check("bp_rel2_data", out_data, pat(3));
        in_valid = 1'b0;
        cyc();
        check("bp_rel3_valid", 64'(out_valid), 64'd0);

        // 4: out-of-range select on the 6-input instance
        in_valid6 = 1'b1; in_sel6 = 3'd7;
        cyc();
        check("oor_data", out_data6, 64'd0);
        check("oor_err", 64'(out_err6), 64'd1);
        check("oor_sel", 64'(out_sel6), 64'd7);
        in_sel6 = 3'd5;
        cyc();
        check("inr_data", out_data6, pat(5));
        check("inr_err", 64'(out_err6), 64'd0);
        check("inr_sel", 64'(out_sel6), 64'd5);
        in_valid6 = 1'b0;
        cyc();
        check("oor_drain", 64'(out_valid6), 64'd0);

        // 5: async reset while FULL
        in_valid = 1'b1; out_ready = 1'b0; in_sel = 3'd4;
        cyc();
        in_sel = 3'd5;
        cyc();
        check("full_rdy", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_data", out_data, 64'd0);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("post_rst_valid_%0d", i), 64'(out_valid), 64'd0);
        end

        // 6: random traffic against a scoreboard queue
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_sel    = 3'($urandom_range(0, 7));
            for (int k = 0; k < 16; k++) in_data[k*32 +: 32] = $urandom;
            check("rnd_valid", 64'(out_valid), 64'(sb_q.size() > 0));
            check("rnd_rdy", 64'(in_ready), 64'(sb_q.size() < 2));
            acc = in_valid && in_ready;
            emt = out_valid && out_ready;
            if (emt && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rnd_data", out_data, e.data);
                check("rnd_sel", 64'(out_sel), 64'(e.sel));
            end
            if (acc) begin
                exp_d = in_data[in_sel*64 +: 64];
                sb_q.push_back('{data: exp_d, sel: in_sel});
            end
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4 && sb_q.size() > 0; c++) begin
            e = sb_q.pop_front();
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_data", out_data, e.data);
            cyc();
        end
        check("drain_empty_q", 64'(sb_q.size()), 64'd0);
        check("drain_empty", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
